// File: rtl/mul_shift_pkg.sv
// Shared operation encoding and width helpers for the multiply/shift cell.
package mul_shift_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    OP_MUL_LO = 3'd0,
    OP_MUL_HI = 3'd1,
    OP_SLL    = 3'd2,
    OP_SRL    = 3'd3,
    OP_SRA    = 3'd4,
    OP_ROL    = 3'd5,
    OP_ROR    = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_shift_barrel.sv
// Combinational shifter/rotator for SLL/SRL/SRA/ROL/ROR; zero latency, no flow control.
// Non-shift opcodes yield 0; the caller muxes in the multiplier result.
module mul_shift_barrel
  import mul_shift_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SHW    = clog2(DATA_W)
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] src,
  input  logic [SHW-1:0]    amt,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] rol_dat;
  logic [DATA_W-1:0] ror_dat;

  // Rotates shift a doubled copy of the operand and keep the window that wraps.
  always_comb begin
    rol_dat = DATA_W'(({src, src} << amt) >> DATA_W);
    ror_dat = DATA_W'({src, src} >> amt);
    case (op)
      OP_SLL:  result = src << amt;
      OP_SRL:  result = src >> amt;
      OP_SRA:  result = $signed(src) >>> amt;
      OP_ROL:  result = rol_dat;
      OP_ROR:  result = ror_dat;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mul_shift_cell.sv
// Pipelined multiply/shift/rotate cell; result valid exactly STAGES cycles after accept.
// A stalled output freezes every stage (in_ready low); flush drops all in-flight work.
module mul_shift_cell
  import mul_shift_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_src1_signed,
  input  logic              in_src2_signed,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int SHW = clog2(DATA_W);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] dat;
  } stage_t;

  stage_t stg [STAGES];

  logic                advance;
  logic                accept;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   shift_res;
  logic [DATA_W-1:0]   comb_res;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~flush & ~reset;
  assign accept   = in_valid & in_ready;

  // Operands are extended per their signed flag; the low 2*DATA_W bits of this
  // product match the (DATA_W+1)-bit signed product, so one multiplier serves both MUL ops.
  assign mul_a   = {{DATA_W{in_src1_signed & in_src1[DATA_W-1]}}, in_src1};
  assign mul_b   = {{DATA_W{in_src2_signed & in_src2[DATA_W-1]}}, in_src2};
  assign product = mul_a * mul_b;

  mul_shift_barrel #(
    .DATA_W (DATA_W),
    .SHW    (SHW)
  ) u_barrel (
    .op     (op_e'(in_op)),
    .src    (in_src1),
    .amt    (in_src2[SHW-1:0]),
    .result (shift_res)
  );

  always_comb begin
    case (op_e'(in_op))
      OP_MUL_LO: comb_res = product[DATA_W-1:0];
      OP_MUL_HI: comb_res = product[2*DATA_W-1:DATA_W];
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: comb_res = shift_res;
      default:   comb_res = '0;
    endcase
  end

  // Result is formed ahead of stage 0 and carried through the rest; retiming may
  // redistribute the multiplier across the pass-through stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < STAGES; i++) begin
          stg[i].vld <= 1'b0;
        end
      end else if (advance) begin
        stg[0].vld <= accept;
        for (int i = 1; i < STAGES; i++) begin
          stg[i].vld <= stg[i-1].vld;
        end
      end
      if (accept) begin
        stg[0].dat <= comb_res;
        stg[0].tag <= in_tag;
      end
      if (advance) begin
        for (int i = 1; i < STAGES; i++) begin
          if (stg[i-1].vld) begin
            stg[i].dat <= stg[i-1].dat;
            stg[i].tag <= stg[i-1].tag;
          end
        end
      end
    end
  end

  assign out_valid  = stg[STAGES-1].vld;
  assign out_result = stg[STAGES-1].dat;
  assign out_tag    = stg[STAGES-1].tag;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy = busy | stg[i].vld;
    end
  end

endmodule

// File: tb/tb_mul_shift_cell.sv
// Bench for mul_shift_cell (DATA_W=32, STAGES=2): directed cases plus a randomized scoreboard run.
module tb_mul_shift_cell;

  localparam int DW = 32;
  localparam int ST = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic          in_src1_signed;
  logic          in_src2_signed;
  logic [DW-1:0] in_src1;
  logic [DW-1:0] in_src2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_shift_cell #(.DATA_W(DW), .STAGES(ST), .TAG_W(TW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_src1_signed (in_src1_signed),
    .in_src2_signed (in_src2_signed),
    .in_src1        (in_src1),
    .in_src2        (in_src2),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_tag        (out_tag),
    .busy           (busy)
  );

  // Reference: plain arithmetic on mathematical values, bit-by-bit shifts/rotates.
  function automatic logic [31:0] model(input logic [2:0] op, input logic s1, input logic s2,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    logic signed [127:0] p;
    logic [31:0]         r;
    int                  sh;
    sh = int'(b % 32);
    r  = '0;
    pa = $signed({96'd0, a});
    pb = $signed({96'd0, b});
    if (s1 && a[31]) pa = pa - (128'sd1 <<< 32);
    if (s2 && b[31]) pb = pb - (128'sd1 <<< 32);
    p = pa * pb;
    case (op)
      3'd0: r = a * b;
      3'd1: r = p[63:32];
      3'd2: r = a << sh;
      3'd3: r = a >> sh;
      3'd4: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? a[i + sh] : a[31];
      3'd5: for (int i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
      3'd6: for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive_op(input logic [2:0] op, input logic s1, input logic s2,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    in_valid       = 1'b1;
    in_op          = op;
    in_src1_signed = s1;
    in_src2_signed = s2;
    in_src1        = a;
    in_src2        = b;
    in_tag         = tag;
  endtask

  // Issue one op into an idle pipe and wait for its result; lat = edges from accept, -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic s1, input logic s2,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        output logic [31:0] res, output logic [4:0] tag_o, output int lat);
    int n;
    @(negedge clk);
    drive_op(op, s1, s2, a, b, tag);
    out_ready = 1'b1;
    flush     = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    res   = out_result;
    tag_o = out_tag;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_mul();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic [3:0]  s1v;
    logic [3:0]  s2v;
    logic [31:0] hexp [4];
    s1v  = 4'b0101;
    s2v  = 4'b1001;
    hexp = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_op(3'd0, 1'b0, 1'b0, 32'd7, 32'd6, 5'd3, res, tg, lat);
    total++; if (res !== 32'h2A) begin bad++; $display("FAIL mul_lo_7x6 got=%h want=0000002a", res); end
    total++; if (tg !== 5'd3) begin bad++; $display("FAIL mul_lo_tag got=%0d want=3", tg); end
    total++; if (lat !== ST) begin bad++; $display("FAIL mul_lo_latency got=%0d want=%0d", lat, ST); end
    for (int i = 0; i < 4; i++) begin
      run_op(3'd1, s1v[i], s2v[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i), res, tg, lat);
      total++;
      if (res !== hexp[i]) begin
        bad++; $display("FAIL mul_hi_s%0b%0b got=%h want=%h", s1v[i], s2v[i], res, hexp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_op(3'd0, i[0], i[1], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 8), res, tg, lat);
      total++;
      if (res !== 32'h1) begin bad++; $display("FAIL mul_lo_flags%0d got=%h want=00000001", i, res); end
    end
  endtask

  task automatic test_shift();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic [31:0] sexp [6];
    logic [31:0] amts [2];
    logic [31:0] val;
    sexp = '{32'h10, 32'h08000000, 32'hF8000000, 32'h18, 32'h18000000, 32'h0};
    amts = '{32'd4, 32'd36};
    for (int k = 0; k < 2; k++) begin
      for (int op = 2; op < 8; op++) begin
        run_op(3'(op), 1'b1, 1'b1, 32'h80000001, amts[k], 5'(op), res, tg, lat);
        total++;
        if (res !== sexp[op - 2]) begin
          bad++; $display("FAIL shift_op%0d_amt%0d got=%h want=%h", op, amts[k], res, sexp[op - 2]);
        end
      end
    end
    // Amount 0 (including 32, whose low five bits are 0) leaves the operand untouched.
    for (int op = 2; op < 7; op++) begin
      val = $urandom() | 32'h80000000;
      run_op(3'(op), 1'b0, 1'b0, val, (op % 2 == 0) ? 32'd0 : 32'd32, 5'(op), res, tg, lat);
      total++;
      if (res !== val) begin bad++; $display("FAIL shift_zero_op%0d got=%h want=%h", op, res, val); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op   [4];
    logic        s1   [4];
    logic        s2   [4];
    logic [31:0] a    [4];
    logic [31:0] b    [4];
    logic [4:0]  tg   [4];
    logic [31:0] exp  [4];
    int          sent;
    int          got;
    int          stall_left;
    int          last_cyc;
    bit          seen;
    logic [31:0] snap;
    for (int i = 0; i < 4; i++) begin
      op[i] = 3'($urandom_range(0, 6));
      s1[i] = 1'($urandom_range(0, 1));
      s2[i] = 1'($urandom_range(0, 1));
      a[i]  = $urandom();
      b[i]  = $urandom();
      tg[i] = 5'(i + 20);
      exp[i] = model(op[i], s1[i], s2[i], a[i], b[i]);
    end
    sent = 0; got = 0; stall_left = 0; last_cyc = 0; seen = 0; snap = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1; stall_left = 5; snap = out_result;
      end
      out_ready = (stall_left == 0);
      if (sent < 4) drive_op(op[sent], s1[sent], s2[sent], a[sent], b[sent], tg[sent]);
      else in_valid = 1'b0;
      #1;
      if (stall_left > 0) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        total++; if (out_result !== snap) begin bad++; $display("FAIL stall_result got=%h want=%h", out_result, snap); end
        stall_left--;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        total++; if (out_result !== exp[got]) begin bad++; $display("FAIL b2b_result%0d got=%h want=%h", got, out_result, exp[got]); end
        total++; if (out_tag !== tg[got]) begin bad++; $display("FAIL b2b_tag%0d got=%0d want=%0d", got, out_tag, tg[got]); end
        if (got > 0) begin
          total++; if (cyc != last_cyc + 1) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", got, cyc - last_cyc, 1); end
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
  endtask

  task automatic test_flush();
    bit          leaked;
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    leaked = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 5'd10);
    @(negedge clk);
    drive_op(3'd0, 1'b0, 1'b0, 32'd4, 32'd5, 5'd11);
    @(negedge clk);
    drive_op(3'd0, 1'b0, 1'b0, 32'd6, 32'd7, 5'd12);
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    total++; if ({out_valid, out_tag} !== {1'b1, 5'd10}) begin bad++; $display("FAIL flush_presented got=%b/%0d want=1/10", out_valid, out_tag); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid && (out_tag == 5'd11 || out_tag == 5'd12)) leaked = 1;
    end
    total++; if (leaked) begin bad++; $display("FAIL flush_leak got=1 want=0"); end
    run_op(3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 5'd13, res, tg, lat);
    total++; if (res !== 32'd81 || tg !== 5'd13) begin bad++; $display("FAIL post_flush_op got=%0d/%0d want=81/13", res, tg); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(3'd0, 1'b0, 1'b0, 32'h1234, 32'h10, 5'd7);
    @(negedge clk);
    drive_op(3'd2, 1'b0, 1'b0, 32'h55, 32'd1, 5'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL arst_out_result got=%h want=0", out_result); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    run_op(3'd0, 1'b0, 1'b0, 32'd3, 32'd5, 5'd9, res, tg, lat);
    total++; if (res !== 32'd15) begin bad++; $display("FAIL arst_after_result got=%0d want=15", res); end
    total++; if (lat !== ST) begin bad++; $display("FAIL arst_after_latency got=%0d want=%0d", lat, ST); end
  endtask

  task automatic test_random();
    logic [36:0] exp_q [$];
    logic [36:0] e;
    logic [2:0]  op;
    logic        s1;
    logic        s2;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tg;
    bit          prev_stall;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    prev_stall = 0; prev_res = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_result !== prev_res || out_tag !== prev_tag) begin
          bad++; $display("FAIL rnd_hold got=%h/%0d want=%h/%0d", out_result, out_tag, prev_res, prev_tag);
        end
      end
      op = 3'($urandom_range(0, 7)); s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
      a = $urandom(); b = $urandom(); tg = 5'($urandom_range(0, 31));
      if (cyc >= 400) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        drive_op(op, s1, s2, a, b, tg);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (in_valid && in_ready) exp_q.push_back({tg, model(op, s1, s2, a, b)});
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected got=%h/%0d want=none", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_result} !== e) begin
            bad++; $display("FAIL rnd_result got=%h/%0d want=%h/%0d", out_result, out_tag, e[31:0], e[36:32]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
    end
    in_valid = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_op = '0; in_src1_signed = 1'b0; in_src2_signed = 1'b0;
    in_src1 = '0; in_src2 = '0; in_tag = '0;
    test_reset();
    test_mul();
    test_shift();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
